// File: rtl/heap_sift_up.sv
// heap_sift_up: sift-up insertion engine for a register max-heap (optional i_clear via HEAP_SIFT_UP_CLEAR_EN)
module heap_sift_up #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CAP = 2 ** DEPTH - 1,
  localparam int CW = $clog2(CAP + 1),
  localparam int IW = $clog2(CAP)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
`ifdef HEAP_SIFT_UP_CLEAR_EN
  input  logic                  i_clear,
`endif
  input  logic                  i_push_valid,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_push_ready,
  output logic [DATA_WIDTH-1:0] o_top,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_busy,
  input  logic [IW-1:0]         i_rd_idx,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  typedef enum logic {IDLE, CLIMB} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] heap [CAP];
  logic [CW-1:0] count;
  logic [IW-1:0] cur, par;
  logic clr, accept, swap;
`ifdef HEAP_SIFT_UP_CLEAR_EN
  assign clr = i_clear && state == IDLE;
`else
  assign clr = 1'b0;
`endif
  assign o_count = count;
  assign o_full = count == CW'(CAP);
  assign o_empty = count == '0;
  assign o_busy = state == CLIMB;
  assign o_top = heap[0];
  assign o_push_ready = state == IDLE && !o_full && !i_rst && !clr;
  assign o_rd_data = i_rd_idx < IW'(CAP) ? heap[i_rd_idx] : '0;
  always_comb begin
    par = (cur - 1'b1) >> 1;
    swap = state == CLIMB && cur != '0 && heap[cur] > heap[par];
    accept = i_push_valid && o_push_ready;
    state_nx = state == IDLE ? (accept ? CLIMB : IDLE) : (swap ? CLIMB : IDLE);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      count <= '0;
      cur <= '0;
      for (int i = 0; i < CAP; i++) heap[i] <= '0;
    end else begin
      state <= state_nx;
      if (clr) begin
        count <= '0;
        for (int i = 0; i < CAP; i++) heap[i] <= '0;
      end else if (accept) begin
        heap[count[IW-1:0]] <= i_push_data;
        count <= count + 1'b1;
        cur <= count[IW-1:0];
      end else if (swap) begin
        heap[cur] <= heap[par];
        heap[par] <= heap[cur];
        cur <= par;
      end
    end
  end
endmodule
